// File: rtl/trace_pkg.sv
// Shared types and default dimensions for the trace buffer and the upstream packer.
package trace_pkg;
  localparam int TRACE_N          = 8;
  localparam int TRACE_DATA_WIDTH = 32;
  localparam int TRACE_TB_SIZE    = 16;

  typedef enum logic [1:0] {IDLE, RD, OUT} state_t;

  typedef logic [TRACE_DATA_WIDTH-1:0] vec_t [TRACE_N-1:0];
endpackage

// File: rtl/tb_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module tb_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/trace_buffer.sv
// Circular trace buffer: captures packed vectors while tracing, drains oldest-first
// over valid/ready once tracing stops.
//
// state | meaning
// IDLE  | capturing (if tracing) or waiting for a drain request
// RD    | RAM read data for rd_ptr is available; load vector_out
// OUT   | vector_out presented, waiting for ready_in
module trace_buffer
  import trace_pkg::*;
#(
  parameter int N          = TRACE_N,
  parameter int DATA_WIDTH = TRACE_DATA_WIDTH,
  parameter int TB_SIZE    = TRACE_TB_SIZE,
  parameter int CNT_W      = $clog2(TB_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tracing,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] vector_in [N],
  input  logic                  drain,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] vector_out [N],
  output logic                  valid_out,
  output logic                  last_out,
  output logic [CNT_W-1:0]      entries,
  output logic                  overflow,
  output logic                  busy
);
  localparam int PW = $clog2(TB_SIZE);
  localparam int VW = N * DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(TB_SIZE);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr, oldest, raddr;
  logic            wr_en, rd_en, start, load, consume, abort;
  logic [VW-1:0]   wdata, rdata;

  assign wr_en  = valid_in && tracing;
  assign oldest = wr_ptr - entries[PW-1:0];
  assign busy   = (state != IDLE);

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign wdata[g*DATA_WIDTH +: DATA_WIDTH] = vector_in[g];
  end

  tb_ram #(.DEPTH(TB_SIZE), .WIDTH(VW), .AW(PW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The RAM read is issued on the transition into RD so its data lands during RD.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load      = 1'b0;
    consume   = 1'b0;
    abort     = 1'b0;
    rd_en     = 1'b0;
    raddr     = rd_ptr;
    case (state)
      IDLE: begin
        if (drain && !tracing && entries != '0) begin
          start     = 1'b1;
          rd_en     = 1'b1;
          raddr     = oldest;
          state_nxt = RD;
        end
      end
      RD: begin
        if (tracing) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          load      = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (tracing) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (ready_in) begin
          consume = 1'b1;
          if (entries == ONE) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RD;
            rd_en     = 1'b1;
            raddr     = rd_ptr + PW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Writes need tracing=1 and consumes need tracing=0, so the two never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      entries   <= '0;
      overflow  <= 1'b0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      for (int i = 0; i < N; i++) vector_out[i] <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (entries == FULL) overflow <= 1'b1;
        else                 entries  <= entries + ONE;
      end
      if (start) rd_ptr <= oldest;
      if (load) begin
        for (int i = 0; i < N; i++) vector_out[i] <= rdata[i*DATA_WIDTH +: DATA_WIDTH];
        valid_out <= 1'b1;
        last_out  <= (entries == ONE);
      end
      if (abort) begin
        valid_out <= 1'b0;
        last_out  <= 1'b0;
      end
      if (consume) begin
        valid_out <= 1'b0;
        last_out  <= 1'b0;
        entries   <= entries - ONE;
        rd_ptr    <= rd_ptr + PW'(1);
        if (entries == ONE) overflow <= 1'b0;
      end
    end
  end
endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
Circular trace buffer directly downstream of the data packer. It captures each full packed N-lane vector while tracing is active, keeping the most recent TB_SIZE vectors and overwriting the oldest. When tracing stops, a drain request streams the stored vectors out oldest-first over a valid/ready interface to the host readout path.

Parameters:
N, 8, lanes per vector (matches packer N)
DATA_WIDTH, 32, bits per lane
TB_SIZE, 16, vector entries stored; power of two, >=2
CNT_W, $clog2(TB_SIZE+1), width of the entry count

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
tracing  input  1  capture enable, common with packer
valid_in  input  1  packer valid_out; one vector this cycle
vector_in  input  N x DATA_WIDTH  packer vector_out
drain  input  1  one-cycle pulse; start readout
ready_in  input  1  consumer accepts vector_out
vector_out  output  N x DATA_WIDTH  drained vector, registered
valid_out  output  1  vector_out valid
last_out  output  1  qualifies final vector of a drain
entries  output  CNT_W  vectors currently stored
overflow  output  1  sticky; at least one entry overwritten since last drain completed
busy  output  1  high in RD or OUT state

Behaviour:
- Reset, when rst_n is low and asynchronous: all of the following are 0:
  - wr_ptr, rd_ptr, entries, overflow
  - valid_out, last_out, busy
  - vector_out
  - State goes to IDLE. Memory contents are not reset.
- Write rule: valid_in && tracing writes mem[wr_ptr] <= vector_in.
  - wr_ptr increments and wraps from TB_SIZE-1 to 0.
  - entries increments by 1, saturating at TB_SIZE; the registered entries value is visible the next cycle.
  - A write when entries==TB_SIZE overwrites the oldest entry and sets overflow.
  - valid_in with tracing=0 is ignored.
- Oldest-entry address is (wr_ptr - entries) mod TB_SIZE.
- FSM states: IDLE, RD, OUT.
- IDLE:
  - drain && !tracing && entries>0: rd_ptr <= oldest address; go to RD.
  - drain while tracing=1 or entries==0 is ignored.
- RD: memory read of mem[rd_ptr]; vector_out is loaded at the end of the cycle.
  - Set valid_out=1 and last_out=(entries==1); go to OUT.
- OUT: vector_out, valid_out and last_out are held stable until ready_in.
  - On valid_out && ready_in: valid_out <= 0, entries decrements, rd_ptr increments and wraps.
  - If that was the last entry: go to IDLE and clear overflow; otherwise go to RD.
- Latency: drain at cycle t gives first valid_out at t+2.
- Throughput: at most 1 vector per 2 cycles; valid_out deasserts for one cycle between vectors.
- Tracing rises while in RD or OUT (abort):
  - Next state is IDLE and valid_out/last_out drop to 0 next cycle.
  - The entry being presented is NOT consumed, even if ready_in was high that cycle; entries are retained.
  - A same-cycle write proceeds normally.
  - overflow is not cleared.
- Write and consume are never simultaneous, because writes need tracing=1 and tracing=1 aborts the drain.
- drain pulses while busy are ignored.
- rst_n asserted mid-drain: immediate return to reset values; stored data is considered lost.
- Width rules:
  - Pointers are $clog2(TB_SIZE) bits with natural wrap.
  - entries never exceeds TB_SIZE and never underflows.

Decomposition:
- Package trace_pkg holds:
  - The state enum (IDLE, RD, OUT).
  - A vector typedef: logic [DATA_WIDTH-1:0] vec_t [N-1:0], parameterised via package localparams shared with the packer.
- One natural sub-module: tb_ram, a simple dual-port RAM of TB_SIZE x (N*DATA_WIDTH).
  - One write port, one synchronous read port, no reset.
  - Inferable as block RAM.

Test Plan:
- Basic capture/drain (TB_SIZE=16):
  - Stimulus: tracing=1; write vectors whose lane0 = 1,2,3; tracing=0; drain; ready_in=1.
  - Required response: entries reads 3 before drain; outputs lane0 = 1,2,3 with last_out only on 3; entries then 0; overflow 0; first valid_out exactly 2 cycles after drain.
- Wrap/overflow:
  - Stimulus: write 20 vectors, lane0 = 0..19, then drain.
  - Required response: entries=16 and overflow=1; outputs lane0 = 4..19 in order; overflow clears after the last vector is accepted.
- Backpressure:
  - Stimulus: drain with ready_in low for 5 cycles on the second vector.
  - Required response: vector_out and valid_out stay stable through the stall; no duplicate or skipped entries.
- Abort:
  - Stimulus: 4 entries stored; drain; accept 1 vector; raise tracing while the second is presented with ready_in=1.
  - Required response: valid_out=0 next cycle; entries=3; a new write makes it 4; a subsequent drain outputs the original 2,3,4 and then the new vector.
- Ignored requests:
  - Stimulus: drain with entries=0; drain while tracing=1; valid_in with tracing=0.
  - Required response: no valid_out; entries unchanged; busy stays 0.
- Async reset:
  - Stimulus: assert rst_n low mid-OUT, not aligned to a clock edge.
  - Required response: valid_out, entries and overflow go to 0 immediately; after release, a drain produces no output.
